// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: instruction fetch front end with a 2-entry instruction queue.
//
// The fetch PC drives the instruction memory address directly. The memory
// returns data one cycle after the address is sampled. Each fetched word is
// captured with its PC into a 2-entry queue and presented to the consumer
// with a valid/ready handshake. A redirect reloads the PC, flushes the queue
// and drops any in-flight fetch. While halt is high, no new fetches are issued.
//
// Optional feature (macro FETCH_PERF_CNT_EN): when defined, fetch_count counts
// accepted instructions (wrapping). When undefined, fetch_count is tied to 0.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous active-high reset
//   mem_addr       out  [31:0] word address to instruction memory
//   mem_data       in   [31:0] memory data for the address of the previous edge
//   redirect_valid in   one-cycle PC change request
//   redirect_pc    in   [31:0] new fetch address
//   halt           in   level; blocks new fetches while high
//   ins_valid      out  queue head holds a valid instruction
//   ins_ready      in   consumer accepts the head when high with ins_valid
//   ins_data       out  [31:0] instruction word at queue head
//   ins_pc         out  [31:0] word address of ins_data
//   fetch_count    out  [31:0] accepted instruction count (0 when feature is off)
//
// state  | meaning
// RUN    | fetches may be issued
// HALTED | no new fetches; an in-flight fetch still lands in the queue

module ins_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  // Queue slot 0 is always the head, so the outputs come straight off registers.
  logic        v0, v1;
  logic [31:0] d0, p0, d1, p1;

  logic        pop;
  logic        issue;
  logic [1:0]  occ_after;

  logic        nv0, nv1;
  logic [31:0] nd0, np0, nd1, np1;

  assign mem_addr  = pc;
  assign ins_valid = v0;
  assign ins_data  = d0;
  assign ins_pc    = p0;

  assign pop = v0 & ins_ready;

  // Occupancy after this edge counting the landing in-flight word; a new issue
  // is only allowed if it will still have a free slot when it lands.
  assign occ_after = {1'b0, v0} + {1'b0, v1} + {1'b0, inflight} - {1'b0, pop};

  assign issue = (state == RUN) && !halt && !redirect_valid && (occ_after < 2'd2);

  always_comb begin
    nv0 = v0;
    nv1 = v1;
    nd0 = d0;
    np0 = p0;
    nd1 = d1;
    np1 = p1;
    if (pop) begin
      nv0 = v1;
      nd0 = d1;
      np0 = p1;
      nv1 = 1'b0;
    end
    if (inflight) begin
      if (!nv0) begin
        nv0 = 1'b1;
        nd0 = mem_data;
        np0 = inflight_pc;
      end else begin
        nv1 = 1'b1;
        nd1 = mem_data;
        np1 = inflight_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      d0          <= 32'h0;
      p0          <= 32'h0;
      d1          <= 32'h0;
      p1          <= 32'h0;
    end else begin
      state <= halt ? HALTED : RUN;
      if (redirect_valid) begin
        // Flush wins over pop and over the landing in-flight word.
        pc       <= redirect_pc;
        inflight <= 1'b0;
        v0       <= 1'b0;
        v1       <= 1'b0;
      end else begin
        if (issue) begin
          pc <= pc + 32'd1;
        end
        inflight    <= issue;
        inflight_pc <= pc;
        v0          <= nv0;
        v1          <= nv1;
        d0          <= nd0;
        p0          <= np0;
        d1          <= nd1;
        p1          <= np1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  // An accept in a redirect cycle still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
    end else if (pop) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Testbench for ins_fetch_ctrl: table-driven startup/backpressure/reset
// vectors, hand sequences for redirect, halt and PC wrap, then randomized
// traffic checked against a transaction-level model of the accepted stream.

module tb_ins_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic [31:0] fetch_count;

  ins_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory: M[a] = a + 100.
  initial mem_data = 32'h0;
  always @(posedge clock) mem_data <= mem_addr + 32'd100;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the accepted stream is sequential from the last reset or
  // redirect target, each word equals M[pc].
  logic [31:0] exp_next;
  logic [31:0] accepts;
  int          total_accepts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_count(input logic [31:0] n);
`ifdef FETCH_PERF_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ins_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_next = 32'h0;
    accepts = 32'h0;
  endtask

  // Drive one cycle of inputs, update the model on accept, advance one edge.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rp, input logic h);
    ins_ready = r;
    redirect_valid = rv;
    redirect_pc = rp;
    halt = h;
    if (ins_valid && r) begin
      chk("accept_pc", ins_pc, exp_next);
      chk("accept_data", ins_data, exp_next + 32'd100);
      exp_next = exp_next + 32'd1;
      accepts = accepts + 32'd1;
      total_accepts++;
    end
    if (rv) exp_next = rp;
    @(posedge clock); #1;
    if (rv) chk("flush_valid", {31'h0, ins_valid}, 32'h0);
    chk("fetch_count", fetch_count, exp_count(accepts));
  endtask

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        chk;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } row_t;

  row_t tbl [0:21];

  function automatic row_t mk(input logic rs, input logic rd, input logic c,
                              input logic [31:0] a, input logic v, input logic [31:0] p);
    row_t t;
    t.rst = rs; t.rdy = rd; t.chk = c; t.addr = a; t.vld = v; t.pc = p;
    return t;
  endfunction

  initial begin
    logic [31:0] a_hold;
    logic [31:0] n0;
    int          n;
    logic        halt_r;

    reset = 1'b1;
    ins_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;

    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_data", ins_data, 32'h0);
    chk("rst_pc", ins_pc, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);

    // Backpressure from start, release, mid-stream reset, free-running restart.
    tbl[0] = mk(1, 0, 0, 32'd0, 0, 32'd0);
    tbl[1] = mk(0, 0, 1, 32'd0, 0, 32'd0);
    tbl[2] = mk(0, 0, 1, 32'd1, 0, 32'd0);
    for (int i = 3; i <= 10; i++) tbl[i] = mk(0, 0, 1, 32'd2, 1, 32'd0);
    tbl[11] = mk(0, 1, 1, 32'd2, 1, 32'd0);
    tbl[12] = mk(0, 1, 1, 32'd3, 1, 32'd1);
    tbl[13] = mk(0, 1, 1, 32'd4, 1, 32'd2);
    tbl[14] = mk(0, 1, 1, 32'd5, 1, 32'd3);
    tbl[15] = mk(1, 1, 1, 32'd6, 1, 32'd4);
    tbl[16] = mk(0, 1, 1, 32'd0, 0, 32'd0);
    tbl[17] = mk(0, 1, 1, 32'd1, 0, 32'd0);
    tbl[18] = mk(0, 1, 1, 32'd2, 1, 32'd0);
    tbl[19] = mk(0, 1, 1, 32'd3, 1, 32'd1);
    tbl[20] = mk(0, 1, 1, 32'd4, 1, 32'd2);
    tbl[21] = mk(0, 1, 1, 32'd5, 1, 32'd3);

    for (int i = 0; i <= 21; i++) begin
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_valid", i), {31'h0, ins_valid}, {31'h0, tbl[i].vld});
        if (tbl[i].vld) begin
          chk($sformatf("tbl%0d_pc", i), ins_pc, tbl[i].pc);
          chk($sformatf("tbl%0d_data", i), ins_data, tbl[i].pc + 32'd100);
        end
      end
      reset = tbl[i].rst;
      ins_ready = tbl[i].rdy;
      @(posedge clock); #1;
    end

    // Redirect while the queue holds pc 5 and 6.
    do_reset();
    n = 0;
    while (!(ins_valid && ins_pc == 32'd5) && n < 20) begin
      cyc(1, 0, 32'h0, 0);
      n++;
    end
    chk("reach_pc5", {31'h0, ins_valid && ins_pc == 32'd5}, 32'h1);
    cyc(0, 0, 32'h0, 0);
    chk("q_head5", ins_pc, 32'd5);
    chk("q_addr_hold", mem_addr, 32'd7);
    cyc(0, 1, 32'd40, 0);
    chk("redir_addr", mem_addr, 32'd40);
    n0 = accepts;
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
    chk("redir_accepts", {31'h0, (accepts - n0) >= 32'd3}, 32'h1);

    // Halt for 5 cycles during streaming: no address advance, no loss.
    cyc(1, 0, 32'h0, 1);
    a_hold = mem_addr;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h0, 1);
      chk("halt_addr", mem_addr, a_hold);
    end
    n0 = accepts;
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
    chk("halt_resume", {31'h0, (accepts - n0) >= 32'd3}, 32'h1);

    // PC wrap through 32'hFFFF_FFFF.
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    n0 = accepts;
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
    chk("wrap_accepts", {31'h0, (accepts - n0) >= 32'd3}, 32'h1);

    // Randomized traffic against the stream model.
    halt_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv;
      logic [31:0] rp;
      r = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 99) < 5);
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      if ($urandom_range(0, 9) == 0) halt_r = ~halt_r;
      cyc(r, rv, rp, halt_r);
    end
    chk("liveness", {31'h0, total_accepts > 500}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
